// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side responder for the core's M-stage data port. One 1RW synchronous
// SRAM macro (active-low controls) is shared between the core and the
// management Wishbone slave. The core always wins the port. Wishbone requests
// are served in core-idle cycles and fail with an error pulse if no idle slot
// arrives within TIMEOUT cycles.

module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // core M-stage port
    input  logic                  i_mem_req_M,
    input  logic                  i_mem_write_M,
    input  logic [DATA_WIDTH-1:0] i_data_addr_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    output logic [DATA_WIDTH-1:0] o_read_data_M,
    // management Wishbone slave
    input  logic                  i_wbs_cyc,
    input  logic                  i_wbs_stb,
    input  logic                  i_wbs_we,
    input  logic [3:0]            i_wbs_sel,
    input  logic [31:0]           i_wbs_adr,
    input  logic [31:0]           i_wbs_dat,
    output logic                  o_wbs_ack,
    output logic                  o_wbs_err,
    output logic [31:0]           o_wbs_dat,
    // SRAM macro port
    output logic                  o_sram_csb,
    output logic                  o_sram_web,
    output logic [3:0]            o_sram_wmask,
    output logic [ADDR_W-1:0]     o_sram_addr,
    output logic [DATA_WIDTH-1:0] o_sram_din,
    input  logic [DATA_WIDTH-1:0] i_sram_dout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_ACK,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             core_rd_q, core_rd_d;
    logic             wb_we_q, wb_we_d;
    logic [31:0]      wb_dat_q, wb_dat_d;

    logic             wb_req;
    logic             grant;

    // Address bits outside the word index are deliberately ignored (wrap modulo depth).
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{i_data_addr_M[DATA_WIDTH-1:ADDR_W+2], i_data_addr_M[1:0],
                                i_wbs_adr[31:ADDR_W+2], i_wbs_adr[1:0]};

    assign wb_req = i_wbs_cyc & i_wbs_stb;
    // Wishbone owns the macro only when the core is idle and no response is in flight.
    assign grant  = rst & wb_req & ~i_mem_req_M & ((state_q == S_IDLE) || (state_q == S_WAIT));

    // SRAM port mux: core first, then a granted Wishbone access, else deselected.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_sram_csb   = 1'b1;
        o_sram_web   = 1'b1;
        o_sram_wmask = 4'h0;
        o_sram_addr  = '0;
        o_sram_din   = '0;
        if (rst && i_mem_req_M) begin
            o_sram_csb   = 1'b0;
            o_sram_web   = ~i_mem_write_M;
            o_sram_wmask = 4'hF;
            o_sram_addr  = i_data_addr_M[ADDR_W+1:2];
            o_sram_din   = i_write_data_M;
        end else if (grant) begin
            o_sram_csb   = 1'b0;
            o_sram_web   = ~i_wbs_we;
            o_sram_wmask = i_wbs_sel;
            o_sram_addr  = i_wbs_adr[ADDR_W+1:2];
            o_sram_din   = i_wbs_dat;
        end
    end

    // Wishbone FSM next-state, wait counter and response outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wb_we_d   = wb_we_q;
        wb_dat_d  = wb_dat_q;
        o_wbs_ack = 1'b0;
        o_wbs_err = 1'b0;
        o_wbs_dat = '0;
        unique case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_RESP;
                    wb_we_d = i_wbs_we;
                end else if (wb_req) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!wb_req) begin
                    state_d = S_IDLE;       // master gave up: silent abort
                    cnt_d   = '0;
                end else if (grant) begin
                    state_d = S_RESP;
                    wb_we_d = i_wbs_we;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = S_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                // Macro output is valid now; writes return zero data.
                wb_dat_d = wb_we_q ? 32'h0 : i_sram_dout;
                state_d  = S_ACK;
            end
            S_ACK: begin
                o_wbs_ack = 1'b1;
                o_wbs_dat = wb_dat_q;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                o_wbs_err = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Core load tracking: the macro answers one cycle after the access.
    always_comb begin
        core_rd_d     = i_mem_req_M & ~i_mem_write_M;
        o_read_data_M = core_rd_q ? i_sram_dout : '0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            core_rd_q <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_dat_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            core_rd_q <= core_rd_d;
            wb_we_q   <= wb_we_d;
            wb_dat_q  <= wb_dat_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Bench for dmem_responder: behavioural SRAM macro, transaction-level
// reference model checked every cycle, plus directed scenarios with literal
// expectations.

module tb_dmem_responder;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_req_M, i_mem_write_M;
    logic [31:0] i_data_addr_M, i_write_data_M, o_read_data_M;
    logic        i_wbs_cyc, i_wbs_stb, i_wbs_we;
    logic [3:0]  i_wbs_sel;
    logic [31:0] i_wbs_adr, i_wbs_dat;
    logic        o_wbs_ack, o_wbs_err;
    logic [31:0] o_wbs_dat;
    logic        o_sram_csb, o_sram_web;
    logic [3:0]  o_sram_wmask;
    logic [7:0]  o_sram_addr;
    logic [31:0] o_sram_din, i_sram_dout;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_mem_req_M    (i_mem_req_M),
        .i_mem_write_M  (i_mem_write_M),
        .i_data_addr_M  (i_data_addr_M),
        .i_write_data_M (i_write_data_M),
        .o_read_data_M  (o_read_data_M),
        .i_wbs_cyc      (i_wbs_cyc),
        .i_wbs_stb      (i_wbs_stb),
        .i_wbs_we       (i_wbs_we),
        .i_wbs_sel      (i_wbs_sel),
        .i_wbs_adr      (i_wbs_adr),
        .i_wbs_dat      (i_wbs_dat),
        .o_wbs_ack      (o_wbs_ack),
        .o_wbs_err      (o_wbs_err),
        .o_wbs_dat      (o_wbs_dat),
        .o_sram_csb     (o_sram_csb),
        .o_sram_web     (o_sram_web),
        .o_sram_wmask   (o_sram_wmask),
        .o_sram_addr    (o_sram_addr),
        .o_sram_din     (o_sram_din),
        .i_sram_dout    (i_sram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural 1RW SRAM macro, cleared once at start of simulation.
    logic        mem_clear;
    logic [31:0] sram_mem [256];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= 32'h0;
            i_sram_dout <= 32'h0;
        end else if (!o_sram_csb) begin
            if (!o_sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (o_sram_wmask[b]) sram_mem[o_sram_addr][8*b +: 8] <= o_sram_din[8*b +: 8];
            end else begin
                i_sram_dout <= sram_mem[o_sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction view: a Wishbone request ages while the core holds the port;
    // it is served in the first core-idle cycle (ack two cycles later) or
    // errors after TIMEOUT+1 busy cycles. No new request is accepted until the
    // cycle after its ack/err.
    logic [31:0] ref_mem [256];
    initial begin : model
        int          ncyc, ack_at, err_at, free_from, age;
        logic        pend, granted, core, req, rd_v;
        logic [31:0] rd_d, ack_data;
        logic [7:0]  wa, ca;
        logic        e_csb, e_web;
        logic [3:0]  e_mask;
        logic [7:0]  e_addr;
        logic [31:0] e_din;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ncyc = 0; ack_at = -1; err_at = -1; free_from = 0; age = 0;
        pend = 1'b0; rd_v = 1'b0; rd_d = 32'h0; ack_data = 32'h0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst) begin
                check("rst_ack",  32'(o_wbs_ack), 32'h0);
                check("rst_err",  32'(o_wbs_err), 32'h0);
                check("rst_wdat", o_wbs_dat, 32'h0);
                check("rst_rdat", o_read_data_M, 32'h0);
                check("rst_csb",  32'(o_sram_csb), 32'h1);
                check("rst_web",  32'(o_sram_web), 32'h1);
                pend = 1'b0; ack_at = -1; err_at = -1; free_from = 0; rd_v = 1'b0;
            end else begin
                // registered responses promised in earlier cycles
                check("m_ack",  32'(o_wbs_ack), 32'(ncyc == ack_at));
                check("m_err",  32'(o_wbs_err), 32'(ncyc == err_at));
                check("m_wdat", o_wbs_dat, (ncyc == ack_at) ? ack_data : 32'h0);
                check("m_rdat", o_read_data_M, rd_v ? rd_d : 32'h0);
                // this cycle's arbitration
                core    = i_mem_req_M;
                req     = i_wbs_cyc & i_wbs_stb;
                granted = 1'b0;
                if (req && ncyc >= free_from) begin
                    if (!pend) begin pend = 1'b1; age = 0; end
                    if (!core) begin
                        granted = 1'b1;
                    end else begin
                        age++;
                        if (age == TIMEOUT + 1) begin
                            pend = 1'b0; err_at = ncyc + 1; free_from = ncyc + 2;
                        end
                    end
                end else if (!req) begin
                    pend = 1'b0;
                end
                ca = i_data_addr_M[9:2];
                wa = i_wbs_adr[9:2];
                e_csb = 1'b1; e_web = 1'b1; e_mask = 4'h0; e_addr = 8'h0; e_din = 32'h0;
                if (core) begin
                    e_csb = 1'b0; e_web = ~i_mem_write_M; e_mask = 4'hF; e_addr = ca; e_din = i_write_data_M;
                end else if (granted) begin
                    e_csb = 1'b0; e_web = ~i_wbs_we; e_mask = i_wbs_sel; e_addr = wa; e_din = i_wbs_dat;
                end
                check("m_csb",  32'(o_sram_csb), 32'(e_csb));
                check("m_web",  32'(o_sram_web), 32'(e_web));
                check("m_mask", 32'(o_sram_wmask), 32'(e_mask));
                if (!e_csb) check("m_addr", 32'(o_sram_addr), 32'(e_addr));
                if (!e_csb && !e_web) check("m_din", o_sram_din, e_din);
                // memory effects
                rd_v = core & ~i_mem_write_M;
                rd_d = ref_mem[ca];
                if (core && i_mem_write_M) ref_mem[ca] = i_write_data_M;
                if (granted) begin
                    pend = 1'b0; ack_at = ncyc + 2; free_from = ncyc + 3;
                    if (i_wbs_we) begin
                        for (int b = 0; b < 4; b++)
                            if (i_wbs_sel[b]) ref_mem[wa][8*b +: 8] = i_wbs_dat[8*b +: 8];
                        ack_data = 32'h0;
                    end else begin
                        ack_data = ref_mem[wa];
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_idle();
        i_mem_req_M = 1'b0; i_mem_write_M = 1'b0; i_data_addr_M = 32'h0; i_write_data_M = 32'h0;
    endtask

    task automatic core_op(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        i_mem_req_M = 1'b1; i_mem_write_M = we; i_data_addr_M = adr; i_write_data_M = dat;
    endtask

    task automatic wb_idle();
        i_wbs_cyc = 1'b0; i_wbs_stb = 1'b0; i_wbs_we = 1'b0;
        i_wbs_sel = 4'h0; i_wbs_adr = 32'h0; i_wbs_dat = 32'h0;
    endtask

    task automatic wb_op(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        i_wbs_cyc = 1'b1; i_wbs_stb = 1'b1; i_wbs_we = we;
        i_wbs_sel = sel; i_wbs_adr = adr; i_wbs_dat = dat;
    endtask

    // Bounded wait for an ack; returns cycles waited from the calling cycle.
    task automatic wait_ack(input int budget, output int waited);
        waited = 0;
        while (!o_wbs_ack && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int waited, errs, acks, err_cyc;
        rst = 1'b0; mem_clear = 1'b1;
        core_idle(); wb_idle();
        tick();
        mem_clear = 1'b0;
        check("reset_ack",  32'(o_wbs_ack), 32'h0);
        check("reset_err",  32'(o_wbs_err), 32'h0);
        check("reset_csb",  32'(o_sram_csb), 32'h1);
        check("reset_rdat", o_read_data_M, 32'h0);
        check("reset_wdat", o_wbs_dat, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // core store then load of the same word
        core_op(1'b1, 32'h10, 32'hDEADBEEF); tick();
        core_op(1'b0, 32'h10, 32'h0);        tick();
        core_idle();
        check("core_ld_data", o_read_data_M, 32'hDEADBEEF);

        // byte-masked Wishbone write over 0x12345678, then read back
        core_op(1'b1, 32'h20, 32'h12345678); tick();
        core_idle();
        wb_op(1'b1, 4'b0011, 32'h20, 32'hAAAA5555);
        wait_ack(8, waited);
        check("wb_wr_ack_lat", 32'(waited), 32'd2);
        wb_idle(); tick();
        wb_op(1'b0, 4'hF, 32'h20, 32'h0);
        wait_ack(8, waited);
        check("wb_rd_ack_lat", 32'(waited), 32'd2);
        check("wb_rd_data", o_wbs_dat, 32'h12345555);
        wb_idle(); tick();

        // Wishbone read waits out five busy core cycles
        core_op(1'b0, 32'h10, 32'h0);
        wb_op(1'b0, 4'hF, 32'h20, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        core_idle();
        check("busy_core_rdat", o_read_data_M, 32'hDEADBEEF);
        wait_ack(8, waited);
        check("busy_ack_lat", 32'(waited), 32'd2);
        check("busy_rd_data", o_wbs_dat, 32'h12345555);
        wb_idle(); tick();

        // timeout: core busy well past TIMEOUT cycles
        errs = 0; acks = 0; err_cyc = -1;
        wb_op(1'b0, 4'hF, 32'h24, 32'h0);
        for (int i = 0; i < 22; i++) begin
            core_op(1'b0, 32'(i * 4), 32'h0);
            if (i == 18) wb_idle();
            if (o_wbs_err) begin errs++; err_cyc = i; end
            if (o_wbs_ack) acks++;
            tick();
        end
        core_idle();
        check("to_err_count", 32'(errs), 32'd1);
        check("to_err_cycle", 32'(err_cyc), 32'd17);
        check("to_ack_count", 32'(acks), 32'd0);
        tick();

        // strobe dropped while waiting: silent abort
        errs = 0; acks = 0;
        core_op(1'b0, 32'h0, 32'h0);
        wb_op(1'b0, 4'hF, 32'h28, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        wb_idle();
        for (int i = 0; i < 7; i++) begin
            if (i == 2) core_idle();
            if (o_wbs_err) errs++;
            if (o_wbs_ack) acks++;
            tick();
        end
        check("abort_err", 32'(errs), 32'd0);
        check("abort_ack", 32'(acks), 32'd0);
        check("abort_csb", 32'(o_sram_csb), 32'h1);

        // reset pulsed while the response is in flight
        wb_op(1'b0, 4'hF, 32'h20, 32'h0);
        tick();
        rst = 1'b0; wb_idle();
        #1;
        check("rstmid_ack",  32'(o_wbs_ack), 32'h0);
        check("rstmid_err",  32'(o_wbs_err), 32'h0);
        check("rstmid_csb",  32'(o_sram_csb), 32'h1);
        check("rstmid_wdat", o_wbs_dat, 32'h0);
        check("rstmid_rdat", o_read_data_M, 32'h0);
        tick();
        rst = 1'b1;
        errs = 0; acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (o_wbs_err) errs++;
            if (o_wbs_ack) acks++;
            tick();
        end
        check("rstmid_post_ack", 32'(acks), 32'd0);
        check("rstmid_post_err", 32'(errs), 32'd0);

        // address 0x400 aliases word 0
        wb_op(1'b1, 4'hF, 32'h400, 32'hCAFEF00D);
        wait_ack(8, waited);
        check("alias_ack_lat", 32'(waited), 32'd2);
        wb_idle(); tick();
        core_op(1'b0, 32'h0, 32'h0); tick();
        core_idle();
        check("alias_rdat", o_read_data_M, 32'hCAFEF00D);

        // core store then Wishbone read of the same word next cycle
        core_op(1'b1, 32'h30, 32'h11111111); tick();
        core_idle();
        wb_op(1'b0, 4'hF, 32'h30, 32'h0);
        wait_ack(8, waited);
        check("order_wb_rd", o_wbs_dat, 32'h11111111);
        wb_idle(); tick();

        // Wishbone write then core load of the same word next cycle
        wb_op(1'b1, 4'hF, 32'h34, 32'h22222222); tick();
        core_op(1'b0, 32'h34, 32'h0);            tick();
        check("order_ack", 32'(o_wbs_ack), 32'h1);
        core_idle();
        check("order_core_rd", o_read_data_M, 32'h22222222);
        wb_idle(); tick();

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
